// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, control-word layout, ALUOp codes
// and the slot-B occupancy states used by the decode stage.
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // Control word: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]}
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        B_EMPTY = 2'd0,
        B_FRESH = 2'd1,
        B_HELD  = 2'd2
    } b_state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode-to-control-word decoder. Opcodes outside the supported
// set (including j, which needs no datapath control here) produce an all-zero word.
module main_decoder
    import mips_pkg::*;
(
    input  logic [5:0]        opcode,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OPC_RTYPE: begin
                ctrl[CTRL_REGDST]                  = 1'b1;
                ctrl[CTRL_REGWRITE]                = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_RTYPE;
            end
            OPC_LW: begin
                ctrl[CTRL_ALUSRC]                  = 1'b1;
                ctrl[CTRL_MEMTOREG]                = 1'b1;
                ctrl[CTRL_REGWRITE]                = 1'b1;
                ctrl[CTRL_MEMREAD]                 = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_MEM;
            end
            OPC_SW: begin
                ctrl[CTRL_ALUSRC]                  = 1'b1;
                ctrl[CTRL_MEMWRITE]                = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_MEM;
            end
            OPC_BEQ: begin
                ctrl[CTRL_BRANCH]                  = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_BEQ;
            end
            OPC_ADDI: begin
                ctrl[CTRL_ALUSRC]                  = 1'b1;
                ctrl[CTRL_REGWRITE]                = 1'b1;
                ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO]  = ALUOP_MEM;
            end
            OPC_J:   ctrl = '0;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: slot A addresses the register file, slot B aligns its
// one-cycle read latency, repairs write/read collisions and feeds the ID/EX bundle.
module id_stage
    import mips_pkg::*;
#(
    parameter int              PC_W   = 32,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [PC_W-1:0]   if_pc,
    output logic              id_ready,
    output logic [4:0]        read1,
    output logic [4:0]        read2,
    input  logic [31:0]       data1,
    input  logic [31:0]       data2,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [31:0]       wb_write_data,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [31:0]       ex_rs_val,
    output logic [31:0]       ex_rt_val,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic              a_valid_q, a_valid_d;
    logic [31:0]       a_instr_q, a_instr_d;
    logic [PC_W-1:0]   a_pc_q, a_pc_d;

    b_state_e          b_state_q, b_state_d;
    logic [PC_W-1:0]   b_pc_q, b_pc_d;
    logic [4:0]        b_rs_q, b_rs_d;
    logic [4:0]        b_rt_q, b_rt_d;
    logic [4:0]        b_rd_q, b_rd_d;
    logic [15:0]       b_imm16_q, b_imm16_d;
    logic [CTRL_W-1:0] b_ctrl_q, b_ctrl_d;
    logic [31:0]       b_rs_val_q, b_rs_val_d;
    logic [31:0]       b_rt_val_q, b_rt_val_d;
    logic              b_byp1_q, b_byp1_d;
    logic              b_byp2_q, b_byp2_d;

    logic              ex_valid_q, ex_valid_d;
    logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic [31:0]       ex_rs_val_q, ex_rs_val_d;
    logic [31:0]       ex_rt_val_q, ex_rt_val_d;
    logic [31:0]       ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;

    logic [4:0]        a_rs, a_rt;
    logic [CTRL_W-1:0] a_ctrl;
    logic              b_occupied;
    logic              load_use;
    logic              a_move;
    logic              a_accept;
    logic              a_byp1, a_byp2;
    logic              wb_hits_rs, wb_hits_rt;
    logic [31:0]       rs_res, rt_res;

    assign a_rs = a_instr_q[25:21];
    assign a_rt = a_instr_q[20:16];

    main_decoder u_main_decoder (
        .opcode (a_instr_q[31:26]),
        .ctrl   (a_ctrl)
    );

    assign read1 = a_valid_q ? a_rs : 5'd0;
    assign read2 = a_valid_q ? a_rt : 5'd0;

    assign b_occupied = (b_state_q != B_EMPTY);

    assign load_use = a_valid_q && b_occupied && b_ctrl_q[CTRL_MEMREAD] &&
                      (b_rt_q != 5'd0) && ((a_rs == b_rt_q) || (a_rt == b_rt_q));

    // A advances whenever B is free or B issues this edge; the hazard holds it back.
    assign a_move   = a_valid_q && !load_use && (!b_occupied || !ex_hold) && !flush;
    assign id_ready = !(load_use || (ex_hold && a_valid_q && b_occupied));
    assign a_accept = if_valid && id_ready && !flush;

    assign a_byp1 = wb_reg_write && (wb_write_reg == a_rs) && (a_rs != 5'd0);
    assign a_byp2 = wb_reg_write && (wb_write_reg == a_rt) && (a_rt != 5'd0);

    assign wb_hits_rs = wb_reg_write && (wb_write_reg == b_rs_q) && (b_rs_q != 5'd0);
    assign wb_hits_rt = wb_reg_write && (wb_write_reg == b_rt_q) && (b_rt_q != 5'd0);

    // The register file output is only trustworthy in the cycle right after the
    // A->B move; after that, B relies on its own latched copy.
    always_comb begin
        rs_res = data1;
        if (b_rs_q == 5'd0) begin
            rs_res = '0;
        end else if ((b_state_q == B_HELD) || b_byp1_q) begin
            rs_res = b_rs_val_q;
        end

        rt_res = data2;
        if (b_rt_q == 5'd0) begin
            rt_res = '0;
        end else if ((b_state_q == B_HELD) || b_byp2_q) begin
            rt_res = b_rt_val_q;
        end
    end

    always_comb begin
        a_valid_d = a_valid_q;
        a_instr_d = a_instr_q;
        a_pc_d    = a_pc_q;

        if (flush) begin
            a_valid_d = 1'b0;
        end else if (a_accept) begin
            a_valid_d = 1'b1;
            a_instr_d = if_instr;
            a_pc_d    = if_pc;
        end else if (a_move) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        b_state_d  = b_state_q;
        b_pc_d     = b_pc_q;
        b_rs_d     = b_rs_q;
        b_rt_d     = b_rt_q;
        b_rd_d     = b_rd_q;
        b_imm16_d  = b_imm16_q;
        b_ctrl_d   = b_ctrl_q;
        b_rs_val_d = b_rs_val_q;
        b_rt_val_d = b_rt_val_q;
        b_byp1_d   = b_byp1_q;
        b_byp2_d   = b_byp2_q;

        if (flush) begin
            b_state_d = B_EMPTY;
        end else if (a_move) begin
            b_state_d  = B_FRESH;
            b_pc_d     = a_pc_q;
            b_rs_d     = a_rs;
            b_rt_d     = a_rt;
            b_rd_d     = a_instr_q[15:11];
            b_imm16_d  = a_instr_q[15:0];
            b_ctrl_d   = a_ctrl;
            b_byp1_d   = a_byp1;
            b_byp2_d   = a_byp2;
            b_rs_val_d = a_byp1 ? wb_write_data : '0;
            b_rt_val_d = a_byp2 ? wb_write_data : '0;
        end else if (b_occupied && ex_hold) begin
            // Latch resolved operands and keep snooping writeback while stalled.
            b_state_d  = B_HELD;
            b_byp1_d   = 1'b0;
            b_byp2_d   = 1'b0;
            b_rs_val_d = wb_hits_rs ? wb_write_data : rs_res;
            b_rt_val_d = wb_hits_rt ? wb_write_data : rt_res;
        end else if (b_occupied) begin
            b_state_d = B_EMPTY;
        end
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_pc_d     = ex_pc_q;
        ex_rs_val_d = ex_rs_val_q;
        ex_rt_val_d = ex_rt_val_q;
        ex_imm_d    = ex_imm_q;
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        ex_rd_d     = ex_rd_q;
        ex_ctrl_d   = ex_ctrl_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (!ex_hold) begin
            ex_valid_d  = b_occupied;
            ex_pc_d     = b_pc_q;
            ex_rs_val_d = rs_res;
            ex_rt_val_d = rt_res;
            ex_imm_d    = sign_ext16(b_imm16_q);
            ex_rs_d     = b_rs_q;
            ex_rt_d     = b_rt_q;
            ex_rd_d     = b_rd_q;
            ex_ctrl_d   = b_ctrl_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_q   <= 1'b0;
            a_instr_q   <= '0;
            a_pc_q      <= '0;
            b_state_q   <= B_EMPTY;
            b_pc_q      <= '0;
            b_rs_q      <= '0;
            b_rt_q      <= '0;
            b_rd_q      <= '0;
            b_imm16_q   <= '0;
            b_ctrl_q    <= '0;
            b_rs_val_q  <= '0;
            b_rt_val_q  <= '0;
            b_byp1_q    <= 1'b0;
            b_byp2_q    <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= RST_PC;
            ex_rs_val_q <= '0;
            ex_rt_val_q <= '0;
            ex_imm_q    <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_ctrl_q   <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_instr_q   <= a_instr_d;
            a_pc_q      <= a_pc_d;
            b_state_q   <= b_state_d;
            b_pc_q      <= b_pc_d;
            b_rs_q      <= b_rs_d;
            b_rt_q      <= b_rt_d;
            b_rd_q      <= b_rd_d;
            b_imm16_q   <= b_imm16_d;
            b_ctrl_q    <= b_ctrl_d;
            b_rs_val_q  <= b_rs_val_d;
            b_rt_val_q  <= b_rt_val_d;
            b_byp1_q    <= b_byp1_d;
            b_byp2_q    <= b_byp2_d;
            ex_valid_q  <= ex_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_rs_val_q <= ex_rs_val_d;
            ex_rt_val_q <= ex_rt_val_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_rd_q     <= ex_rd_d;
            ex_ctrl_q   <= ex_ctrl_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_pc     = ex_pc_q;
    assign ex_rs_val = ex_rs_val_q;
    assign ex_rt_val = ex_rt_val_q;
    assign ex_imm    = ex_imm_q;
    assign ex_rs     = ex_rs_q;
    assign ex_rt     = ex_rt_q;
    assign ex_rd     = ex_rd_q;
    assign ex_ctrl   = ex_ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with a register-file model whose reads return the
// pre-write value on a same-edge write, so collisions must be repaired by the stage.
module tb_id_stage;
    import mips_pkg::*;

    localparam logic [31:0] I_ADD_3_1_2  = 32'h0022_1820;
    localparam logic [31:0] I_LW_2_0_1   = 32'h8C22_0000;
    localparam logic [31:0] I_ADD_3_2_2  = 32'h0042_1820;
    localparam logic [31:0] I_ADD_4_1_0  = 32'h0020_2020;
    localparam logic [31:0] I_ADDI_5_0_M = 32'h2005_FFFF;
    localparam logic [31:0] I_UNKNOWN    = 32'hFC22_1820;
    localparam logic [31:0] CTRL_RTYPE   = 32'h0000_0122;
    localparam logic [31:0] CTRL_LW      = 32'h0000_00F0;
    localparam logic [31:0] CTRL_ADDI    = 32'h0000_00A0;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              id_ready;
    logic [4:0]        read1, read2;
    logic [31:0]       data1, data2;
    logic              wb_reg_write;
    logic [4:0]        wb_write_reg;
    logic [31:0]       wb_write_data;
    logic              ex_hold;
    logic              flush;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    logic [31:0] rf [32];
    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        data1 <= rf[read1];
        data2 <= rf[read2];
        if (wb_reg_write && wb_write_reg != 5'd0) rf[wb_write_reg] <= wb_write_data;
    end

    id_stage #(.PC_W(32), .RST_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready),
        .read1         (read1),
        .read2         (read2),
        .data1         (data1),
        .data2         (data2),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_rs_val     (ex_rs_val),
        .ex_rt_val     (ex_rt_val),
        .ex_imm        (ex_imm),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .ex_ctrl       (ex_ctrl)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic setWb(input logic en, input logic [4:0] rd, input logic [31:0] val);
        wb_reg_write  = en;
        wb_write_reg  = rd;
        wb_write_data = val;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rst = 1'b1;
        ex_hold = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0);
        setWb(1'b0, '0, '0);
        #2 rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_ex_pc", ex_pc, 32'd0);
        checkOutput("rst_id_ready", {31'd0, id_ready}, 32'd1);
        checkOutput("rst_read1", {27'd0, read1}, 32'd0);
        checkOutput("rst_ex_ctrl", {23'd0, ex_ctrl}, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        $display("[TB] basic add latency");
        applyStimulus(1'b1, I_ADD_3_1_2, 32'h100);
        checkOutput("t1_ready", {31'd0, id_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("t1_read1", {27'd0, read1}, 32'd1);
        checkOutput("t1_read2", {27'd0, read2}, 32'd2);
        tick();
        checkOutput("t1_not_yet", {31'd0, ex_valid}, 32'd0);
        tick();
        checkOutput("t1_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("t1_pc", ex_pc, 32'h100);
        checkOutput("t1_rs_val", ex_rs_val, 32'd5);
        checkOutput("t1_rt_val", ex_rt_val, 32'd7);
        checkOutput("t1_rd", {27'd0, ex_rd}, 32'd3);
        checkOutput("t1_ctrl", {23'd0, ex_ctrl}, CTRL_RTYPE);

        $display("[TB] same-edge writeback collision");
        applyStimulus(1'b1, I_ADD_3_1_2, 32'h104);
        tick();
        applyStimulus(1'b0, '0, '0);
        setWb(1'b1, 5'd1, 32'h1234);
        tick();
        setWb(1'b0, '0, '0);
        tick();
        checkOutput("t2_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("t2_rs_bypass", ex_rs_val, 32'h1234);
        checkOutput("t2_rt_val", ex_rt_val, 32'd7);

        $display("[TB] load-use bubble");
        applyStimulus(1'b1, I_LW_2_0_1, 32'h200);
        tick();
        applyStimulus(1'b1, I_ADD_3_2_2, 32'h204);
        checkOutput("t3_ready_pre", {31'd0, id_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("t3_ready_stall", {31'd0, id_ready}, 32'd0);
        tick();
        checkOutput("t3_lw_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("t3_lw_pc", ex_pc, 32'h200);
        checkOutput("t3_lw_ctrl", {23'd0, ex_ctrl}, CTRL_LW);
        checkOutput("t3_ready_post", {31'd0, id_ready}, 32'd1);
        tick();
        checkOutput("t3_bubble", {31'd0, ex_valid}, 32'd0);
        tick();
        checkOutput("t3_add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("t3_add_pc", ex_pc, 32'h204);
        checkOutput("t3_add_rs", ex_rs_val, 32'd7);

        $display("[TB] ex_hold with writeback snoop");
        applyStimulus(1'b1, I_ADD_3_1_2, 32'h2F0);
        tick();
        applyStimulus(1'b1, I_ADD_4_1_0, 32'h300);
        tick();
        applyStimulus(1'b0, '0, '0);
        tick();
        checkOutput("t4_first_pc", ex_pc, 32'h2F0);
        ex_hold = 1'b1;
        tick();
        checkOutput("t4_frozen_pc1", ex_pc, 32'h2F0);
        checkOutput("t4_ready_hold", {31'd0, id_ready}, 32'd1);
        setWb(1'b1, 5'd1, 32'h99);
        tick();
        setWb(1'b0, '0, '0);
        tick();
        checkOutput("t4_frozen_pc3", ex_pc, 32'h2F0);
        checkOutput("t4_frozen_rd", {27'd0, ex_rd}, 32'd3);
        checkOutput("t4_frozen_valid", {31'd0, ex_valid}, 32'd1);
        ex_hold = 1'b0;
        tick();
        checkOutput("t4_rel_pc", ex_pc, 32'h300);
        checkOutput("t4_rel_rs", ex_rs_val, 32'h99);
        checkOutput("t4_rel_rt", ex_rt_val, 32'd0);
        checkOutput("t4_rel_rd", {27'd0, ex_rd}, 32'd4);

        $display("[TB] flush");
        applyStimulus(1'b1, I_ADD_3_1_2, 32'h400);
        tick();
        applyStimulus(1'b1, I_ADD_4_1_0, 32'h404);
        tick();
        applyStimulus(1'b1, I_ADD_3_1_2, 32'h408);
        checkOutput("t5_a_full", {27'd0, read1}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t5_ex_killed", {31'd0, ex_valid}, 32'd0);
        checkOutput("t5_a_empty", {27'd0, read1}, 32'd0);
        applyStimulus(1'b1, I_ADD_3_1_2, 32'h40C);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("t5_e0_invalid", {31'd0, ex_valid}, 32'd0);
        tick();
        checkOutput("t5_e1_invalid", {31'd0, ex_valid}, 32'd0);
        tick();
        checkOutput("t5_next_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("t5_next_pc", ex_pc, 32'h40C);
        checkOutput("t5_next_rs", ex_rs_val, 32'h99);

        $display("[TB] addi sign extension and r0");
        applyStimulus(1'b1, I_ADDI_5_0_M, 32'h500);
        tick();
        applyStimulus(1'b0, '0, '0);
        setWb(1'b1, 5'd0, 32'hDEAD);
        tick();
        setWb(1'b0, '0, '0);
        tick();
        checkOutput("t6_imm", ex_imm, 32'hFFFF_FFFF);
        checkOutput("t6_rs_zero", ex_rs_val, 32'd0);
        checkOutput("t6_rt", {27'd0, ex_rt}, 32'd5);
        checkOutput("t6_ctrl", {23'd0, ex_ctrl}, CTRL_ADDI);

        $display("[TB] unknown opcode then async reset");
        applyStimulus(1'b1, I_UNKNOWN, 32'h600);
        tick();
        applyStimulus(1'b1, I_ADD_3_1_2, 32'h700);
        tick();
        applyStimulus(1'b0, '0, '0);
        tick();
        checkOutput("t7_unk_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("t7_unk_ctrl", {23'd0, ex_ctrl}, 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("t7_rst_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("t7_rst_ready", {31'd0, id_ready}, 32'd1);
        checkOutput("t7_rst_pc", ex_pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("t7_no_partial", {31'd0, ex_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
